// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit combinational full adder; the only arithmetic in the serial adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: LSB-first over WIDTH clocks with a carry flop.
// Optional macro SERIAL_ADDER_OVF_EN adds a signed-overflow output.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             overflow,
`endif
  output logic [1:0]       dbg_state
);

  // Handshake: start is accepted only in IDLE or DONE; busy is high while
  // bits are being added; done pulses for one cycle when result is valid.

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_result_next;
  logic [CNT_W-1:0] r_count;
  logic             r_c;
  logic             r_carry_out;
  logic             w_sum;
  logic             w_cout;
  logic             w_accept;
  logic             w_last;
`ifdef SERIAL_ADDER_OVF_EN
  logic             r_overflow;
`endif

  full_adder_cell u_fa (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .cin  (r_c),
    .sum  (w_sum),
    .cout (w_cout)
  );

  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last   = (r_count == LAST_CNT);

  // New sum bit enters at the MSB so the LSB-first stream lands in place.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_result_next = w_sum;
    end else begin : g_wn
      assign w_result_next = {w_sum, r_result[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next_state = ST_SHIFT;
      ST_SHIFT: if (w_last) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = start ? ST_SHIFT : ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_result    <= '0;
      r_count     <= '0;
      r_c         <= 1'b0;
      r_carry_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      r_overflow  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a_sh   <= op_a;
      r_b_sh   <= op_b;
      r_c      <= carry_in;
      r_count  <= '0;
      r_result <= '0;
    end else if (r_state == ST_SHIFT) begin
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_result <= w_result_next;
      r_c      <= w_cout;
      r_count  <= r_count + CNT_W'(1);
      if (w_last) begin
        r_carry_out <= w_cout;
`ifdef SERIAL_ADDER_OVF_EN
        // r_c here is the carry into the MSB cell.
        r_overflow  <= r_c ^ w_cout;
`endif
      end
    end
  end

  assign busy      = (r_state == ST_SHIFT);
  assign done      = (r_state == ST_DONE);
  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign dbg_state = r_state;
`ifdef SERIAL_ADDER_OVF_EN
  assign overflow  = r_overflow;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl at WIDTH=1, 8 and 13 against an arithmetic model.
module tb_serial_adder_ctrl;
  import serial_adder_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [12:0] op_a;
  logic [12:0] op_b;
  logic        carry_in;
  logic        start1, start8, start13;
  logic        busy1, busy8, busy13;
  logic        done1, done8, done13;
  logic [0:0]  res1;
  logic [7:0]  res8;
  logic [12:0] res13;
  logic        co1, co8, co13;
  logic [1:0]  dbg1, dbg8, dbg13;
`ifdef SERIAL_ADDER_OVF_EN
  logic        ovf1, ovf8, ovf13;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  serial_adder_ctrl #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op_a(op_a[0:0]), .op_b(op_b[0:0]),
    .carry_in(carry_in), .busy(busy1), .done(done1), .result(res1), .carry_out(co1),
`ifdef SERIAL_ADDER_OVF_EN
    .overflow(ovf1),
`endif
    .dbg_state(dbg1)
  );

  serial_adder_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op_a(op_a[7:0]), .op_b(op_b[7:0]),
    .carry_in(carry_in), .busy(busy8), .done(done8), .result(res8), .carry_out(co8),
`ifdef SERIAL_ADDER_OVF_EN
    .overflow(ovf8),
`endif
    .dbg_state(dbg8)
  );

  serial_adder_ctrl #(.WIDTH(13)) u13 (
    .clk(clk), .rst_n(rst_n), .start(start13), .op_a(op_a), .op_b(op_b),
    .carry_in(carry_in), .busy(busy13), .done(done13), .result(res13), .carry_out(co13),
`ifdef SERIAL_ADDER_OVF_EN
    .overflow(ovf13),
`endif
    .dbg_state(dbg13)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic done_of(input int w);
    case (w)
      1: return done1;
      8: return done8;
      default: return done13;
    endcase
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      1: return busy1;
      8: return busy8;
      default: return busy13;
    endcase
  endfunction

  function automatic logic [12:0] res_of(input int w);
    case (w)
      1: return {12'd0, res1};
      8: return {5'd0, res8};
      default: return res13;
    endcase
  endfunction

  function automatic logic co_of(input int w);
    case (w)
      1: return co1;
      8: return co8;
      default: return co13;
    endcase
  endfunction

`ifdef SERIAL_ADDER_OVF_EN
  function automatic logic ovf_of(input int w);
    case (w)
      1: return ovf1;
      8: return ovf8;
      default: return ovf13;
    endcase
  endfunction
`endif

  task automatic set_start(input int w, input logic v);
    case (w)
      1: start1 = v;
      8: start8 = v;
      default: start13 = v;
    endcase
  endtask

  // driver + reference model: one add on the instance of width w
  task automatic do_add(input int w, input logic [12:0] a, input logic [12:0] b,
                        input logic c, input string tag);
    int mask, am, bm, tot, n, busy_cnt;
    logic got;
    mask = (1 << w) - 1;
    am   = int'(a) & mask;
    bm   = int'(b) & mask;
    tot  = am + bm + int'(c);
    @(negedge clk);
    op_a = a; op_b = b; carry_in = c;
    set_start(w, 1'b1);
    n = 0; busy_cnt = 0; got = 1'b0;
    while (n < 60 && !got) begin
      @(negedge clk);
      set_start(w, 1'b0);
      n++;
      if (busy_of(w)) busy_cnt++;
      if (done_of(w)) got = 1'b1;
      else begin
        op_a = 13'($urandom); op_b = 13'($urandom); carry_in = 1'($urandom);
      end
    end
    chk({tag, "_latency"}, got ? n : -1, w + 1);
    chk({tag, "_busy_cycles"}, busy_cnt, w);
    chk({tag, "_result"}, {19'd0, res_of(w)}, tot & mask);
    chk({tag, "_carry_out"}, {31'd0, co_of(w)}, (tot >> w) & 1);
`ifdef SERIAL_ADDER_OVF_EN
    begin
      int sa, sb, ss, half;
      half = 1 << (w - 1);
      sa = (am >= half) ? am - (1 << w) : am;
      sb = (bm >= half) ? bm - (1 << w) : bm;
      ss = sa + sb + int'(c);
      chk({tag, "_overflow"}, {31'd0, ovf_of(w)}, (ss >= half || ss < -half) ? 1 : 0);
    end
`endif
  endtask

  initial begin
    int w, dones;
    rst_n = 1'b0; start1 = 1'b0; start8 = 1'b0; start13 = 1'b0;
    op_a = '0; op_b = '0; carry_in = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_result", res8, 0);
    chk("rst_carry", co8, 0);
    chk("rst_state", {dbg1, dbg8, dbg13}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_done", {done1, done8, done13}, 0);

    // directed sums
    do_add(8, 13'h35, 13'h4A, 1'b0, "add_35_4a");
    chk("add_35_4a_value", res8, 8'h7F);
    do_add(8, 13'hFF, 13'h01, 1'b0, "add_ff_01");
    do_add(8, 13'hFF, 13'hFF, 1'b1, "add_ff_ff_c");
    chk("add_ff_ff_c_value", {co8, res8}, 9'h1FF);
    do_add(1, 13'h1, 13'h1, 1'b1, "w1_111");
    do_add(13, 13'h1FFF, 13'h0001, 1'b0, "w13_wrap");
`ifdef SERIAL_ADDER_OVF_EN
    do_add(8, 13'h7F, 13'h01, 1'b0, "ovf_7f_01");
    chk("ovf_7f_01_flag", ovf8, 1);
    do_add(8, 13'h80, 13'hFF, 1'b0, "ovf_80_ff");
    chk("ovf_80_ff_flag", {ovf8, co8}, 2'b11);
    do_add(8, 13'h10, 13'h20, 1'b0, "ovf_10_20");
    chk("ovf_10_20_flag", ovf8, 0);
`endif

    // start held high: back-to-back adds, start during busy ignored
    @(negedge clk);
    op_a = 13'h12; op_b = 13'h34; carry_in = 1'b1; start8 = 1'b1;
    for (int n = 1; n <= 19; n++) begin
      @(negedge clk);
      if (n == 9) begin
        chk("b2b_done1", done8, 1);
        chk("b2b_res1", {co8, res8}, 9'h047);
        op_a = 13'h0F0; op_b = 13'h00F; carry_in = 1'b1;
      end else if (n == 18) begin
        chk("b2b_done2", done8, 1);
        chk("b2b_res2", {co8, res8}, 9'h100);
        start8 = 1'b0;
      end else if (n == 19) begin
        chk("b2b_idle", {done8, busy8, dbg8}, {1'b0, 1'b0, ST_IDLE});
      end else begin
        chk($sformatf("b2b_busy_%0d", n), {done8, busy8}, 2'b01);
        op_a = 13'($urandom); op_b = 13'($urandom); carry_in = 1'($urandom);
      end
    end

    // reset in the 4th SHIFT cycle aborts the add
    @(negedge clk);
    op_a = 13'h35; op_b = 13'h4A; carry_in = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", busy8, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {busy8, done8, co8, res8}, 11'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done8) dones++;
    end
    chk("abort_no_done", dones, 0);
    do_add(8, 13'h35, 13'h4A, 1'b0, "after_abort");

    // random adds on all three widths
    for (int i = 0; i < 1000; i++) begin
      w = (i % 3 == 0) ? 1 : ((i % 3 == 1) ? 8 : 13);
      do_add(w, 13'($urandom), 13'($urandom), 1'($urandom_range(0, 1)), $sformatf("rnd_w%0d", w));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
